// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: FSM state encoding and default bit period shared by the FIFO-fed UART transmitter.
package fifo_uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;
    localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts cycles within a serial bit; bit_tick marks the cycle just before a bit's
//   final cycle so the transmitter can register its bit-boundary decisions without a combinational path.
module uart_baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
    logic [CW-1:0] cnt_q, cnt_d;
    // Held at zero while disabled, so every frame restarts from a clean bit boundary.
    always_comb begin
        cnt_d = (!enable || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
    assign bit_tick = enable && cnt_q == PRE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream Sync_FIFO and serialises them as UART frames
//   (start, LSB-first data, optional even parity, stop); every output is a flop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              parity_q, parity_d;
    logic              rd_en_q, rd_en_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              tx_done_q, tx_done_d;
    logic              bit_end_q, bit_end_d;
    logic              bit_tick, baud_en;
    assign baud_en = state_q inside {S_START, S_DATA, S_PARITY, S_STOP};
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock    (clock),
        .reset    (reset),
        .enable   (baud_en),
        .bit_tick (bit_tick)
    );
    // bit_end_q is high on the final cycle of each serial bit; tx_d is the value for the next bit.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        rd_en_d   = 1'b0;
        tx_done_d = 1'b0;
        bit_end_d = bit_tick;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                    rd_en_d = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d   = fifo_data;
                parity_d  = ^fifo_data;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = S_START;
            end
            S_START: if (bit_end_q) begin
                tx_d    = shreg_q[0];
                state_d = S_DATA;
            end
            S_DATA: if (bit_end_q) begin
                if (bit_cnt_q == LAST_BIT) begin
                    tx_d    = PARITY_EN ? parity_q : 1'b1;
                    state_d = PARITY_EN ? S_PARITY : S_STOP;
                end else begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    tx_d      = shreg_d[0];
                end
            end
            S_PARITY: if (bit_end_q) begin
                tx_d    = 1'b1;
                state_d = S_STOP;
            end
            S_STOP: begin
                tx_done_d = bit_tick;
                if (bit_end_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
            bit_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            rd_en_q   <= rd_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
            bit_end_q <= bit_end_d;
        end
    end
    assign rd_en   = rd_en_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (no parity / even parity) each fed by a behavioural 8-deep FIFO;
//   a per-channel line monitor decodes frames and scores them against the pushed bytes.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    typedef struct {
        int         ch;
        logic [7:0] data;
        logic [11:0] frame;
    } vec_t;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rd_en, tx, busy, tx_done, fempty;
    logic [1:0] wr_en = 2'b00;
    logic [7:0] wr_data [2];
    logic [7:0] fdata [2] = '{8'h00, 8'h00};
    logic [7:0] mem [2][8];
    int wp [2] = '{0, 0};
    int rp [2] = '{0, 0};
    int cnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int nfr [2] = '{0, 0};
    int st [2][$];
    int en [2][$];
    logic [7:0]  exp_q [2][$];
    logic [11:0] last_bits [2];
    int rd_on_empty = 0;
    int cyc = 0;
    int push_cyc = 0;
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;
    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .fifo_data(fdata[0]), .fifo_empty(fempty[0]),
        .rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );
    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .fifo_data(fdata[1]), .fifo_empty(fempty[1]),
        .rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );
    assign fempty[0] = cnt[0] == 0;
    assign fempty[1] = cnt[1] == 0;
    always @(posedge clock) begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (rd_en[c]) rd_cnt[c]++;
            if (rd_en[c] && cnt[c] == 0) rd_on_empty++;
            if (rd_en[c] && cnt[c] > 0) begin
                fdata[c] <= mem[c][rp[c]];
                rp[c] <= (rp[c] + 1) % 8;
            end
            if (wr_en[c] && cnt[c] < 8) begin
                mem[c][wp[c]] <= wr_data[c];
                wp[c] <= (wp[c] + 1) % 8;
            end
            cnt[c] <= cnt[c] + int'(wr_en[c] && cnt[c] < 8) - int'(rd_en[c] && cnt[c] > 0);
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    function automatic logic [11:0] frame_of(input logic [7:0] d, input int par);
        logic [11:0] f;
        f = '0;
        f[8:1] = d;
        if (par != 0) begin
            f[9]  = ^d;
            f[10] = 1'b1;
        end else f[9] = 1'b1;
        return f;
    endfunction
    task automatic mon(input int c);
        logic [11:0] bits;
        logic [7:0]  e;
        int nb, dn, s0;
        logic dl, ok;
        forever begin
            @(negedge clock);
            if (reset || tx[c] !== 1'b0) continue;
            nb = (c != 0) ? 11 : 10;
            s0 = cyc;
            bits = '0;
            dn = 0;
            dl = 1'b0;
            ok = 1'b1;
            for (int k = 0; k < nb * CPB; k++) begin
                if (k > 0) @(negedge clock);
                if (reset) begin
                    ok = 1'b0;
                    break;
                end
                if (k % CPB == 0) bits[k / CPB] = tx[c];
                else chk($sformatf("bit_stable%0d", c), tx[c], bits[k / CPB]);
                if (tx_done[c]) dn++;
                if (k == nb * CPB - 1) dl = tx_done[c];
            end
            if (!ok) begin
                if (exp_q[c].size() > 0) void'(exp_q[c].pop_front());
                continue;
            end
            chk($sformatf("tx_done_count%0d", c), dn, 1);
            chk($sformatf("tx_done_last%0d", c), dl, 1);
            chk($sformatf("frame_expected%0d", c), exp_q[c].size() > 0, 1);
            if (exp_q[c].size() > 0) begin
                e = exp_q[c].pop_front();
                chk($sformatf("frame_model%0d", c), bits, frame_of(e, c));
            end
            st[c].push_back(s0);
            en[c].push_back(cyc);
            last_bits[c] = bits;
            nfr[c]++;
        end
    endtask
    initial mon(0);
    initial mon(1);
    task automatic push(input int c, input logic [7:0] d);
        wr_en[c] = 1'b1;
        wr_data[c] = d;
        exp_q[c].push_back(d);
        @(negedge clock);
        wr_en[c] = 1'b0;
        push_cyc = cyc;
    endtask
    task automatic wait_frames(input int c, input int n);
        int t;
        t = 0;
        while (nfr[c] < n && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk($sformatf("frame_timeout%0d", c), nfr[c] >= n, 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end
    initial begin
        vec_t tbl [6];
        int n, r0, t, c;
        tbl[0] = '{ch: 0, data: 8'hA5, frame: 12'h34A};
        tbl[1] = '{ch: 1, data: 8'h07, frame: 12'h60E};
        tbl[2] = '{ch: 1, data: 8'h03, frame: 12'h406};
        tbl[3] = '{ch: 0, data: 8'h00, frame: 12'h200};
        tbl[4] = '{ch: 1, data: 8'hFF, frame: 12'h5FE};
        tbl[5] = '{ch: 0, data: 8'h80, frame: 12'h300};
        #16 reset = 1'b0;
        @(negedge clock);
        repeat (100) begin
            @(negedge clock);
            chk("idle0", {tx[0], rd_en[0], busy[0], tx_done[0]}, 4'b1000);
            chk("idle1", {tx[1], rd_en[1], busy[1], tx_done[1]}, 4'b1000);
        end
        foreach (tbl[i]) begin
            c = tbl[i].ch;
            n = nfr[c];
            r0 = rd_cnt[c];
            push(c, tbl[i].data);
            wait_frames(c, n + 1);
            chk($sformatf("vec%0d_frame", i), last_bits[c], tbl[i].frame);
            chk($sformatf("vec%0d_latency", i), st[c][n] - push_cyc, 3);
            chk($sformatf("vec%0d_len", i), en[c][n] - st[c][n] + 1, (c != 0) ? 44 : 40);
            @(negedge clock);
            chk($sformatf("vec%0d_busy", i), busy[c], 0);
            chk($sformatf("vec%0d_rd", i), rd_cnt[c] - r0, 1);
        end
        n = nfr[0];
        r0 = rd_cnt[0];
        push(0, 8'h10);
        push(0, 8'h20);
        push(0, 8'h30);
        wait_frames(0, n + 3);
        @(negedge clock);
        chk("b2b_rd", rd_cnt[0] - r0, 3);
        chk("b2b_empty", fempty[0], 1);
        for (int j = 0; j < 2; j++) chk($sformatf("b2b_gap%0d", j), st[0][n + j + 1] - en[0][n + j] - 1, 3);
        n = nfr[0];
        push(0, 8'($urandom));
        t = 0;
        while (!busy[0] && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("fill_busy", busy[0], 1);
        repeat (3) @(negedge clock);
        for (int j = 0; j < 8; j++) push(0, 8'($urandom));
        chk("fill_full", cnt[0], 8);
        wait_frames(0, n + 9);
        n = nfr[1];
        for (int j = 0; j < 20; j++) begin
            t = 0;
            while (cnt[1] >= 8 && t < 500) begin
                @(negedge clock);
                t++;
            end
            repeat ($urandom_range(0, 50)) @(negedge clock);
            push(1, 8'($urandom));
        end
        wait_frames(1, n + 20);
        n = nfr[0];
        r0 = rd_cnt[0];
        push(0, 8'h5A);
        push(0, 8'h3C);
        t = 0;
        while (tx[0] !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        repeat (3 * CPB) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk("rst_async", {tx[0], rd_en[0], busy[0], tx_done[0]}, 4'b1000);
        #14 reset = 1'b0;
        wait_frames(0, n + 1);
        chk("rst_next_frame", last_bits[0], 12'h278);
        repeat (60) @(negedge clock);
        chk("rst_frames", nfr[0] - n, 1);
        chk("rst_rd", rd_cnt[0] - r0, 2);
        chk("rd_on_empty", rd_on_empty, 0);
        chk("exp_left0", exp_q[0].size(), 0);
        chk("exp_left1", exp_q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
